con_state_ctl: RTL and testbench
================================

Name: con_state_ctl

Overview:
- Parametrised successor to the fixed 3-bit CON microcode-state latches and the run/halt flops on the CON board.
- Provides an NSTATE-bit microcode state register with set/clear/load/toggle ops from the CRAM # field.
- Adds a run/halt/halt-pending sequencer gated by MBOX activity.
- Adds an EBUS diagnostic readback handshake that drives state and status onto a parametrised EBUS data slice.
- Sits beside the CON condition decoder and feeds EBOX, console and diagnostic logic.

Parameters:
- NSTATE, 8, width of the microcode state register (1..16).
- NR_W, 9, width of the CRAM # field.
- EBUS_W, 18, width of the driven EBUS data slice (at least NSTATE+3).
- HOLD_CYC, 2, cycles EBUS data stays driven after grant (1..7).

Ports:
- clk_con_h  in  1  CON clock.
- mr_reset_l  in  1  asynchronous active-low master reset.
- clk_ebox_sync_h  in  1  EBOX sync; state ops are taken only when high.
- state_op_h  in  2  00 nop, 01 set (OR), 10 clear (ANDN), 11 load.
- state_tog_h  in  1  with op=00, XOR the mask into state.
- cram_nr_h  in  NR_W  # field; low NSTATE bits are the mask/data.
- console_run_h  in  1  console start request (pulse).
- halt_req_h  in  1  microcode or console halt request (pulse or level).
- mbox_busy_h  in  1  MBOX cycle in progress (mcl_mbox_cyc_req or wait).
- diag_read_h  in  1  diagnostic read request (level).
- diag_sel_h  in  1  0 selects the state register, 1 selects the status word.
- ebus_cp_grant_h  in  1  EBUS grant to CON.
- con_ucode_state_h  out  NSTATE  state register.
- con_run_h  out  1  EBOX running.
- con_ebox_halted_h  out  1  halted and quiescent.
- con_halt_pend_h  out  1  halt accepted, waiting on MBOX.
- ebus_d_h  out  EBUS_W  data; zero when not driving.
- ebus_drive_h  out  1  CON driving EBUS.
- ebus_rel_h  out  1  one-cycle release pulse ending a read.

Behaviour:
- Reset (async, mr_reset_l low): state 0; run FSM HALTED; diag FSM IDLE; con_run_h 0; con_ebox_halted_h 1; con_halt_pend_h 0; ebus_d_h 0; ebus_drive_h 0; ebus_rel_h 0. Deassertion is synchronous-released externally; outputs change only at clock edges afterwards.
- State register: updates on a clk_con_h edge only when clk_ebox_sync_h=1. Let m = cram_nr_h[NSTATE-1:0].
  - set: s|m.
  - clear: s&~m.
  - load: m.
  - op=00 with state_tog_h: s^m.
  - op=00 without state_tog_h: hold.
  - Result is visible the next cycle (one-cycle latency). Bits of cram_nr_h above NSTATE are ignored. If NSTATE > NR_W, the upper bits take mask 0.
- Run FSM: HALTED, RUNNING, HALT_PEND.
  - HALTED + console_run_h -> RUNNING.
  - RUNNING + halt_req_h: mbox_busy_h=0 -> HALTED directly; otherwise -> HALT_PEND.
  - HALT_PEND: -> HALTED on the first cycle mbox_busy_h=0. console_run_h is ignored in this state.
  - console_run_h and halt_req_h in the same cycle while HALTED: run wins. While RUNNING: halt wins.
  - Outputs are registered state decodes:
    - con_run_h=(RUNNING|HALT_PEND).
    - con_halt_pend_h=HALT_PEND.
    - con_ebox_halted_h=HALTED.
- Diag FSM: IDLE, WAIT_GNT, DRIVE, REL.
  - IDLE + diag_read_h -> WAIT_GNT, capturing diag_sel_h.
  - WAIT_GNT + ebus_cp_grant_h -> DRIVE. Data is sampled from the current state/status on entry to DRIVE and held constant.
  - DRIVE lasts exactly HOLD_CYC cycles with ebus_drive_h=1, then -> REL.
  - REL lasts 1 cycle with ebus_rel_h=1 and ebus_drive_h=0, then -> IDLE.
  - A new read needs diag_read_h low for at least one cycle in IDLE (edge-qualified). A level held high does not retrigger.
  - Grant lost during DRIVE: drive stops immediately and the FSM goes to REL.
  - diag_read_h dropped in WAIT_GNT: -> IDLE, no drive.
- Data layout:
  - sel=0: ebus_d_h[NSTATE-1:0]=state, upper bits 0.
  - sel=1: bit0 run, bit1 halt_pend, bit2 halted, bit3 mbox_busy, rest 0.
- Reset mid-read forces IDLE and releases EBUS immediately (asynchronously).

Decomposition:
- Package con_state_pkg holds:
  - op enum (NOP/SET/CLR/LOAD).
  - run_state_t {HALTED, RUNNING, HALT_PEND}.
  - diag_state_t {IDLE, WAIT_GNT, DRIVE, REL}.
  - Status bit-position constants.
- One sub-module, con_ebus_diag_rd: diag FSM, hold counter and data mux/hold. Width and HOLD_CYC are passed through.

Test Plan:
- Reset then sync=1, op=11, nr=0x0A5 -> state 0xA5 next cycle. Then op=01, nr=0x100 with NSTATE=8 -> state stays 0xA5.
- state=0xA5, op=10, nr=0x0F, sync=0 -> hold 0xA5. Same with sync=1 -> 0xA0. op=00, tog, nr=0xFF -> 0x5F.
- HALTED, console_run pulse -> con_run_h=1. halt_req with mbox_busy=1 for 3 cycles -> halt_pend=1 for 3 cycles, then halted=1, run=0.
- run and halt in the same cycle from HALTED -> RUNNING. From RUNNING -> HALT_PEND or HALTED according to mbox_busy.
- sel=0, state=0x3C, read, grant after 4 cycles, HOLD_CYC=2 -> ebus_d_h=0x0003C with drive=1 for exactly 2 cycles, then rel=1 for 1 cycle, then d=0.
- Grant dropped in the first DRIVE cycle -> drive=0 next cycle and rel pulse. mr_reset_l low during DRIVE -> drive=0 and d=0 immediately.

Source files
------------

// File: rtl/con_state_pkg.sv
// Shared types and constants for the CON microcode-state and run/halt block.
// Imported by con_state_ctl and its EBUS diagnostic readback sub-module.
package con_state_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_LOAD = 2'b11
    } state_op_t;

    typedef enum logic [1:0] {
        RS_HALTED,
        RS_RUNNING,
        RS_HALT_PEND
    } run_state_t;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_WAIT_GNT,
        DS_DRIVE,
        DS_REL
    } diag_state_t;

    localparam int STAT_RUN       = 0;
    localparam int STAT_HALT_PEND = 1;
    localparam int STAT_HALTED    = 2;
    localparam int STAT_MBOX_BUSY = 3;

endpackage

// File: rtl/con_ebus_diag_rd.sv
// EBUS diagnostic readback: request/grant handshake, hold timer and
// data capture for the CON state register or status word.
module con_ebus_diag_rd
    import con_state_pkg::*;
#(
    parameter int EBUS_W   = 18,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk_con_h,
    input  logic              mr_reset_l,
    input  logic              diag_read_h,
    input  logic              diag_sel_h,
    input  logic              ebus_cp_grant_h,
    input  logic [EBUS_W-1:0] state_word,
    input  logic [EBUS_W-1:0] status_word,
    output logic [EBUS_W-1:0] ebus_d_h,
    output logic              ebus_drive_h,
    output logic              ebus_rel_h
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYC - 1);

    diag_state_t       ds_q, ds_nxt;
    logic [2:0]        hold_q, hold_nxt;
    logic              armed_q, armed_nxt;
    logic              sel_q, sel_nxt;
    logic [EBUS_W-1:0] data_q, data_nxt;

    always_ff @(posedge clk_con_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            ds_q    <= DS_IDLE;
            hold_q  <= '0;
            armed_q <= 1'b1;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            ds_q    <= ds_nxt;
            hold_q  <= hold_nxt;
            armed_q <= armed_nxt;
            sel_q   <= sel_nxt;
            data_q  <= data_nxt;
        end
    end

    // armed_q is only re-set by seeing the request low while idle,
    // so a level held high cannot start a second read.
    always_comb begin
        ds_nxt    = ds_q;
        hold_nxt  = hold_q;
        armed_nxt = armed_q;
        sel_nxt   = sel_q;
        data_nxt  = data_q;
        unique case (ds_q)
            DS_IDLE: begin
                if (diag_read_h && armed_q) begin
                    ds_nxt    = DS_WAIT_GNT;
                    sel_nxt   = diag_sel_h;
                    armed_nxt = 1'b0;
                end else if (!diag_read_h) begin
                    armed_nxt = 1'b1;
                end
            end
            DS_WAIT_GNT: begin
                if (!diag_read_h) begin
                    ds_nxt = DS_IDLE;
                end else if (ebus_cp_grant_h) begin
                    ds_nxt   = DS_DRIVE;
                    hold_nxt = HOLD_LAST;
                    data_nxt = sel_q ? status_word : state_word;
                end
            end
            DS_DRIVE: begin
                if (!ebus_cp_grant_h || hold_q == 3'd0) begin
                    ds_nxt = DS_REL;
                end else begin
                    hold_nxt = hold_q - 3'd1;
                end
            end
            DS_REL: begin
                ds_nxt = DS_IDLE;
            end
        endcase
    end

    assign ebus_drive_h = (ds_q == DS_DRIVE);
    assign ebus_rel_h   = (ds_q == DS_REL);
    assign ebus_d_h     = ebus_drive_h ? data_q : '0;

endmodule

// File: rtl/con_state_ctl.sv
// CON microcode state register, run/halt sequencer and EBUS
// diagnostic readback of state and status.
module con_state_ctl
    import con_state_pkg::*;
#(
    parameter int NSTATE   = 8,
    parameter int NR_W     = 9,
    parameter int EBUS_W   = 18,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk_con_h,
    input  logic              mr_reset_l,
    input  logic              clk_ebox_sync_h,
    input  logic [1:0]        state_op_h,
    input  logic              state_tog_h,
    input  logic [NR_W-1:0]   cram_nr_h,
    input  logic              console_run_h,
    input  logic              halt_req_h,
    input  logic              mbox_busy_h,
    input  logic              diag_read_h,
    input  logic              diag_sel_h,
    input  logic              ebus_cp_grant_h,
    output logic [NSTATE-1:0] con_ucode_state_h,
    output logic              con_run_h,
    output logic              con_ebox_halted_h,
    output logic              con_halt_pend_h,
    output logic [EBUS_W-1:0] ebus_d_h,
    output logic              ebus_drive_h,
    output logic              ebus_rel_h
);

    // Zero-extend so state bits beyond the # field see a zero mask.
    logic [NSTATE+NR_W-1:0] nr_ext;
    logic [NSTATE-1:0]      mask;
    logic                   unused_nr;

    assign nr_ext    = {{NSTATE{1'b0}}, cram_nr_h};
    assign mask      = nr_ext[NSTATE-1:0];
    assign unused_nr = ^nr_ext;

    logic [NSTATE-1:0] state_q, state_nxt;

    always_comb begin
        state_nxt = state_q;
        if (clk_ebox_sync_h) begin
            unique case (state_op_t'(state_op_h))
                OP_SET:  state_nxt = state_q | mask;
                OP_CLR:  state_nxt = state_q & ~mask;
                OP_LOAD: state_nxt = mask;
                OP_NOP: begin
                    if (state_tog_h) state_nxt = state_q ^ mask;
                end
            endcase
        end
    end

    always_ff @(posedge clk_con_h or negedge mr_reset_l) begin
        if (!mr_reset_l) state_q <= '0;
        else             state_q <= state_nxt;
    end

    assign con_ucode_state_h = state_q;

    run_state_t run_q, run_nxt;

    always_ff @(posedge clk_con_h or negedge mr_reset_l) begin
        if (!mr_reset_l) run_q <= RS_HALTED;
        else             run_q <= run_nxt;
    end

    always_comb begin
        run_nxt = run_q;
        unique case (run_q)
            RS_HALTED: begin
                if (console_run_h) run_nxt = RS_RUNNING;
            end
            RS_RUNNING: begin
                if (halt_req_h)
                    run_nxt = mbox_busy_h ? RS_HALT_PEND : RS_HALTED;
            end
            RS_HALT_PEND: begin
                if (!mbox_busy_h) run_nxt = RS_HALTED;
            end
            default: run_nxt = RS_HALTED;
        endcase
    end

    assign con_run_h         = (run_q == RS_RUNNING) ||
                               (run_q == RS_HALT_PEND);
    assign con_halt_pend_h   = (run_q == RS_HALT_PEND);
    assign con_ebox_halted_h = (run_q == RS_HALTED);

    logic [EBUS_W-1:0] state_word;
    logic [EBUS_W-1:0] status_word;

    always_comb begin
        state_word                 = '0;
        state_word[NSTATE-1:0]     = state_q;
        status_word                = '0;
        status_word[STAT_RUN]       = con_run_h;
        status_word[STAT_HALT_PEND] = con_halt_pend_h;
        status_word[STAT_HALTED]    = con_ebox_halted_h;
        status_word[STAT_MBOX_BUSY] = mbox_busy_h;
    end

    con_ebus_diag_rd #(
        .EBUS_W   (EBUS_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_diag (
        .clk_con_h       (clk_con_h),
        .mr_reset_l      (mr_reset_l),
        .diag_read_h     (diag_read_h),
        .diag_sel_h      (diag_sel_h),
        .ebus_cp_grant_h (ebus_cp_grant_h),
        .state_word      (state_word),
        .status_word     (status_word),
        .ebus_d_h        (ebus_d_h),
        .ebus_drive_h    (ebus_drive_h),
        .ebus_rel_h      (ebus_rel_h)
    );

endmodule

// File: tb/tb_con_state_ctl.sv
// Scoreboard bench for con_state_ctl: directed plan steps followed by
// randomized traffic, checked against a behavioural model.
module tb_con_state_ctl;

    localparam int NSTATE   = 8;
    localparam int NR_W     = 9;
    localparam int EBUS_W   = 18;
    localparam int HOLD_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync_i, tog_i, run_i, halt_i, busy_i;
    logic              read_i, sel_i, gnt_i;
    logic [1:0]        op_i;
    logic [NR_W-1:0]   nr_i;
    logic [NSTATE-1:0] st_o;
    logic              run_o, halted_o, pend_o, drv_o, rel_o;
    logic [EBUS_W-1:0] d_o;

    always #5 clk = ~clk;

    con_state_ctl #(
        .NSTATE(NSTATE), .NR_W(NR_W),
        .EBUS_W(EBUS_W), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_con_h         (clk),
        .mr_reset_l        (rst_n),
        .clk_ebox_sync_h   (sync_i),
        .state_op_h        (op_i),
        .state_tog_h       (tog_i),
        .cram_nr_h         (nr_i),
        .console_run_h     (run_i),
        .halt_req_h        (halt_i),
        .mbox_busy_h       (busy_i),
        .diag_read_h       (read_i),
        .diag_sel_h        (sel_i),
        .ebus_cp_grant_h   (gnt_i),
        .con_ucode_state_h (st_o),
        .con_run_h         (run_o),
        .con_ebox_halted_h (halted_o),
        .con_halt_pend_h   (pend_o),
        .ebus_d_h          (d_o),
        .ebus_drive_h      (drv_o),
        .ebus_rel_h        (rel_o)
    );

    typedef struct {
        logic [NSTATE-1:0] st;
        logic [2:0]        rph;
        logic [EBUS_W+1:0] bus;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    // Model: mode 0 halted, 1 running, 2 halt pending.
    // phase 0 idle, 1 awaiting grant, 2 driving, 3 releasing.
    logic [NSTATE-1:0] m_state;
    int                m_mode, m_phase, m_left;
    logic [EBUS_W-1:0] m_data;
    bit                m_armed, m_sel;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h want %0h",
                      name, $time, act, exp);
    endtask

    task automatic model_reset();
        m_state = '0;
        m_mode  = 0;
        m_phase = 0;
        m_left  = 0;
        m_data  = '0;
        m_armed = 1'b1;
        m_sel   = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic drv;
        drv   = (m_phase == 2);
        e.st  = m_state;
        e.rph = {m_mode != 0, m_mode == 2, m_mode == 0};
        e.bus = {drv, m_phase == 3, drv ? m_data : {EBUS_W{1'b0}}};
        return e;
    endfunction

    task automatic set_idle();
        sync_i = 0; op_i = 0; tog_i = 0; nr_i = '0;
        run_i = 0; halt_i = 0; busy_i = 0;
        read_i = 0; sel_i = 0; gnt_i = 0;
    endtask

    task automatic step(input logic sy, input logic [1:0] op,
                        input logic tg, input logic [NR_W-1:0] nr,
                        input logic rn, input logic hl, input logic bz,
                        input logic rd, input logic sl, input logic gn);
        logic [NSTATE-1:0] m;
        logic [EBUS_W-1:0] st_w, stat_w;
        @(negedge clk);
        sync_i = sy; op_i = op; tog_i = tg; nr_i = nr;
        run_i = rn; halt_i = hl; busy_i = bz;
        read_i = rd; sel_i = sl; gnt_i = gn;
        st_w   = EBUS_W'(m_state);
        stat_w = EBUS_W'({bz, m_mode == 0, m_mode == 2, m_mode != 0});
        m = nr[NSTATE-1:0];
        if (sy) begin
            if (op == 2'd1) m_state = m_state | m;
            else if (op == 2'd2) m_state = m_state & ~m;
            else if (op == 2'd3) m_state = m;
            else if (tg) m_state = m_state ^ m;
        end
        if (m_mode == 0 && rn) m_mode = 1;
        else if (m_mode == 1 && hl) m_mode = bz ? 2 : 0;
        else if (m_mode == 2 && !bz) m_mode = 0;
        if (m_phase == 0) begin
            if (rd && m_armed) begin
                m_phase = 1; m_sel = sl; m_armed = 0;
            end else if (!rd) m_armed = 1;
        end else if (m_phase == 1) begin
            if (!rd) m_phase = 0;
            else if (gn) begin
                m_phase = 2; m_left = HOLD_CYC;
                m_data = m_sel ? stat_w : st_w;
            end
        end else if (m_phase == 2) begin
            m_left--;
            if (!gn || m_left == 0) m_phase = 3;
        end else m_phase = 0;
        exp_q.push_back(model_out());
    endtask

    task automatic check_reset_vals();
        check("rst_state", 32'(st_o), 0);
        check("rst_run", {run_o, pend_o, halted_o}, 3'b001);
        check("rst_ebus", {drv_o, rel_o, d_o}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_idle();
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state", 32'(st_o), 32'(e.st));
                check("run_pend_halt", {run_o, pend_o, halted_o}, e.rph);
                check("ebus", {drv_o, rel_o, d_o}, e.bus);
            end
        end
    end

    initial begin : stim
        logic rd;
        set_idle();
        model_reset();
        #3;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // state ops
        step(1, 2'd3, 0, 9'h0A5, 0, 0, 0, 0, 0, 0);
        step(1, 2'd1, 0, 9'h100, 0, 0, 0, 0, 0, 0);
        step(0, 2'd2, 0, 9'h00F, 0, 0, 0, 0, 0, 0);
        step(1, 2'd2, 0, 9'h00F, 0, 0, 0, 0, 0, 0);
        step(1, 2'd0, 1, 9'h0FF, 0, 0, 0, 0, 0, 0);
        step(1, 2'd0, 0, 9'h0FF, 0, 0, 0, 0, 0, 0);

        // run / halt pending / halt
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // state readback, grant after four cycles
        step(1, 2'd3, 0, 9'h03C, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // status readback, grant lost in first drive cycle
        step(0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // request dropped while awaiting grant
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset in the middle of a drive
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        do_reset();

        rd = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 4) == 0) rd = ~rd;
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), NR_W'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1), rd, $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0);
            if (i % 800 == 400) begin
                do_reset();
                rd = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
